// File: rtl/hwpe_stream_merge_narrower_if.sv
// Valid/ready stream carrying one data word plus a byte strobe.
interface hwpe_stream_merge_narrower_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, data, strb, input ready);
    modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_merge_narrower.sv
// Buffers one wide merged word and re-emits it lane by lane (LSB lane first),
// optionally skipping lanes whose strobe is all-zero.
module hwpe_stream_merge_narrower #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NB_LANES   = 2,
    parameter bit          SKIP_EMPTY = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    hwpe_stream_merge_narrower_if.slave   push_i,
    hwpe_stream_merge_narrower_if.master  pop_o,
    output logic [$clog2(NB_LANES)-1:0]   lane_o,
    output logic                          last_o,
    output logic                          busy_o
);
    localparam int unsigned LANE_W      = $clog2(NB_LANES);
    localparam int unsigned STRB_W      = DATA_WIDTH / 8;
    localparam int unsigned WIDE_W      = DATA_WIDTH * NB_LANES;
    localparam int unsigned WIDE_STRB_W = STRB_W * NB_LANES;

    localparam logic [1:0] IDLE  = 2'b01;
    localparam logic [1:0] DRAIN = 2'b10;

    logic [1:0]             state_q, state_d;
    logic [WIDE_W-1:0]      data_q, data_d;
    logic [WIDE_STRB_W-1:0] strb_q, strb_d;
    logic [NB_LANES-1:0]    mask_q, mask_d;

    logic [NB_LANES-1:0]    accept_mask;
    logic [NB_LANES-1:0]    mask_clr;
    logic [LANE_W-1:0]      sel;
    logic                   is_last;
    logic                   draining;
    logic                   push_hs;
    logic                   pop_hs;

    // Lanes that will be emitted for the incoming word
    always_comb begin
        accept_mask = '0;
        for (int unsigned i = 0; i < NB_LANES; i++) begin
            accept_mask[i] = SKIP_EMPTY ? (|push_i.strb[i*STRB_W +: STRB_W]) : 1'b1;
        end
    end

    // Lowest pending lane is the one currently presented
    always_comb begin
        sel = '0;
        for (int i = int'(NB_LANES) - 1; i >= 0; i--) begin
            if (mask_q[i]) sel = LANE_W'(i);
        end
    end

    assign mask_clr = mask_q & ~(NB_LANES'(1) << sel);
    assign is_last  = (mask_clr == '0);
    assign draining = (state_q == DRAIN);

    assign pop_o.valid  = draining;
    assign pop_o.data   = data_q[sel*DATA_WIDTH +: DATA_WIDTH];
    assign pop_o.strb   = strb_q[sel*STRB_W +: STRB_W];
    assign lane_o       = sel;
    assign last_o       = draining & is_last;
    assign busy_o       = draining;
    assign push_i.ready = (state_q == IDLE) | (draining & pop_o.ready & is_last);

    assign push_hs = push_i.valid & push_i.ready;
    assign pop_hs  = draining & pop_o.ready;

    // Next state: a push on the final pop reloads without a bubble
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        strb_d  = strb_q;
        mask_d  = mask_q;
        if (pop_hs) begin
            mask_d = mask_clr;
            if (is_last) state_d = IDLE;
        end
        if (push_hs) begin
            data_d  = push_i.data;
            strb_d  = push_i.strb;
            mask_d  = accept_mask;
            state_d = (accept_mask != '0) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            strb_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            mask_q  <= mask_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
        (pop_o.valid && !pop_o.ready) |=> ($stable(pop_o.data) && $stable(pop_o.strb)));
    assert property (@(posedge clk_i) $onehot0(state_q));
    assert property (@(posedge clk_i) (DATA_WIDTH % 8) == 0);

endmodule
